fetch_unit: RTL and testbench

Instruction fetch stage that produces the 16-bit `IR` consumed by `control_unit`. It holds the program counter, reads the instruction ROM, registers the fetched word into the decode stage, and handles branch redirects, stalls and interrupt entry/return. It closes the loop with the `IEN_d` / `IOF_d` / `RTI_d` and `branch_d` decode outputs.

---
 rtl/processor_defs.sv | 14 +
 rtl/fetch_unit_if.sv | 20 ++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/processor_defs.sv
// Shared processor definitions: the injected NOP encoding, default vectors and
// the fetch FSM state type.
package processor_defs;

   localparam logic [15:0] NOP_WORD             = 16'h0000;
   localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;
   localparam logic [15:0] DEFAULT_IRQ_VECTOR   = 16'h0004;

   typedef enum logic {
      RUN = 1'b0,
      ISR = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction ROM port: the fetch stage drives the address and reads the word
// back combinationally.
interface fetch_unit_if #(
   parameter int unsigned PC_WIDTH = 16
);

   logic [PC_WIDTH-1:0] imem_addr;
   logic [15:0]         imem_data;

   modport master (
      output imem_addr,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      output imem_data
   );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM read, decode-stage IR register, branch
// redirect, stall and single-level interrupt entry/return.
module fetch_unit
   import processor_defs::*;
#(
   parameter int unsigned         PC_WIDTH     = 16,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
   parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = PC_WIDTH'(DEFAULT_IRQ_VECTOR),
   parameter logic [15:0]         NOP          = NOP_WORD
) (
   input  logic                clk,
   input  logic                reset,
   fetch_unit_if.master        imem,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                irq,
   input  logic                IEN_d,
   input  logic                IOF_d,
   input  logic                RTI_d,
   output logic [15:0]         IR,
   output logic [PC_WIDTH-1:0] PC_d,
   output logic                IR_valid,
   output logic                int_enable,
   output logic                in_isr,
   output logic [PC_WIDTH-1:0] epc
);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [15:0]         ir_q, ir_d;
   logic [PC_WIDTH-1:0] dec_pc_q, dec_pc_d;
   logic                valid_q, valid_d;
   logic                ie_q, ie_d;
   logic [PC_WIDTH-1:0] epc_q, epc_d;

   logic irq_entry;
   logic rti_go;

   // A branch in the same cycle outranks the interrupt, so entry is held off.
   assign irq_entry = irq && ie_q && (state_q == RUN) && !branch_taken;
   assign rti_go    = RTI_d && valid_q && !stall && (state_q == ISR);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      ir_d       = ir_q;
      dec_pc_d   = dec_pc_q;
      valid_d    = valid_q;
      ie_d       = ie_q;
      epc_d      = epc_q;

      if (branch_taken) begin
         fetch_pc_d = branch_target;
         ir_d       = NOP;
         valid_d    = 1'b0;
      end else if (irq_entry) begin
         epc_d      = fetch_pc_q;
         fetch_pc_d = IRQ_VECTOR;
         ir_d       = NOP;
         valid_d    = 1'b0;
         ie_d       = 1'b0;
         state_d    = ISR;
      end else if (rti_go) begin
         fetch_pc_d = epc_q;
         ir_d       = NOP;
         valid_d    = 1'b0;
         ie_d       = 1'b1;
         state_d    = RUN;
      end else if (!stall) begin
         ir_d       = imem.imem_data;
         dec_pc_d   = fetch_pc_q;
         valid_d    = 1'b1;
         fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
         // IOF takes precedence when both decode lines are raised.
         if (valid_q) begin
            if (IOF_d) begin
               ie_d = 1'b0;
            end else if (IEN_d) begin
               ie_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_VECTOR;
         ir_q       <= NOP;
         dec_pc_q   <= '0;
         valid_q    <= 1'b0;
         ie_q       <= 1'b0;
         epc_q      <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         ir_q       <= ir_d;
         dec_pc_q   <= dec_pc_d;
         valid_q    <= valid_d;
         ie_q       <= ie_d;
         epc_q      <= epc_d;
      end
   end

   assign imem.imem_addr = fetch_pc_q;
   assign IR             = ir_q;
   assign PC_d           = dec_pc_q;
   assign IR_valid       = valid_q;
   assign int_enable     = ie_q;
   assign in_isr         = (state_q == ISR);
   assign epc            = epc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table walks through
// fetch, branch, IRQ entry/return, stalls and PC wrap, then reset mid-handler.
module tb_fetch_unit;

   localparam logic [15:0] OP_IEN = 16'hF001;
   localparam logic [15:0] OP_IOF = 16'hF002;
   localparam logic [15:0] OP_RTI = 16'hF003;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        irq;
   logic        ien_dec, iof_dec, rti_dec;
   logic [15:0] ir;
   logic [15:0] pc_dec;
   logic        ir_valid, int_enable, in_isr;
   logic [15:0] epc;
   logic [15:0] rom [0:65535];

   int tests_run = 0;
   int tests_failed = 0;

   fetch_unit_if #(.PC_WIDTH(16)) imem_bus ();

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .imem          (imem_bus),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .irq           (irq),
      .IEN_d         (ien_dec),
      .IOF_d         (iof_dec),
      .RTI_d         (rti_dec),
      .IR            (ir),
      .PC_d          (pc_dec),
      .IR_valid      (ir_valid),
      .int_enable    (int_enable),
      .in_isr        (in_isr),
      .epc           (epc)
   );

   always #5 clk = ~clk;

   assign imem_bus.imem_data = rom[imem_bus.imem_addr];

   // Minimal stand-in for control_unit decode of the current IR.
   assign ien_dec = (ir == OP_IEN);
   assign iof_dec = (ir == OP_IOF);
   assign rti_dec = (ir == OP_RTI);

   typedef struct {
      logic        stall;
      logic        br;
      logic [15:0] tgt;
      logic        irq;
      logic [15:0] ir;
      logic [15:0] pcd;
      logic [15:0] addr;
      logic [15:0] epc;
      logic        valid;
      logic        ie;
      logic        isr;
   } vec_t;

   localparam int NumVec = 28;
   vec_t vecs [NumVec];

   function automatic vec_t mk(input logic s, input logic b, input logic [15:0] t,
                               input logic i, input logic [15:0] e_ir,
                               input logic [15:0] e_pcd, input logic [15:0] e_addr,
                               input logic [15:0] e_epc, input logic e_v,
                               input logic e_ie, input logic e_isr);
      vec_t v;
      v.stall = s;     v.br = b;       v.tgt = t;       v.irq = i;
      v.ir = e_ir;     v.pcd = e_pcd;  v.addr = e_addr; v.epc = e_epc;
      v.valid = e_v;   v.ie = e_ie;    v.isr = e_isr;
      return v;
   endfunction

   task automatic step(input logic s, input logic b, input logic [15:0] t, input logic i);
      stall         = s;
      branch_taken  = b;
      branch_target = t;
      irq           = i;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] e_ir, input logic [15:0] e_pcd,
                        input logic [15:0] e_addr, input logic [15:0] e_epc, input logic e_v,
                        input logic e_ie, input logic e_isr);
      logic [66:0] act, exp_v;
      act   = {ir, pc_dec, imem_bus.imem_addr, epc, ir_valid, int_enable, in_isr};
      exp_v = {e_ir, e_pcd, e_addr, e_epc, e_v, e_ie, e_isr};
      tests_run++;
      if (act !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got IR=%h PC_d=%h addr=%h epc=%h v=%b ie=%b isr=%b, want IR=%h PC_d=%h addr=%h epc=%h v=%b ie=%b isr=%b",
                  name, ir, pc_dec, imem_bus.imem_addr, epc, ir_valid, int_enable, in_isr,
                  e_ir, e_pcd, e_addr, e_epc, e_v, e_ie, e_isr);
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) begin
         logic [15:0] aw;
         aw     = 16'(a);
         rom[a] = {4'h5, aw[11:0]};
      end
      rom[0] = 16'h1000;
      rom[1] = 16'h2000;
      rom[2] = 16'h3000;
      rom[3] = OP_IEN;
      rom[4] = 16'h4444;
      rom[5] = OP_RTI;
      rom[6] = OP_IOF;
      rom[7] = OP_IEN;

      //                stall br  target    irq  IR        PC_d      addr      epc       v     ie    isr
      vecs[0]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h1000, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h2000, 16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h3000, 16'h0002, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, OP_IEN,   16'h0003, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h4444, 16'h0004, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0);
      vecs[5]  = mk(1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0004, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b0);
      vecs[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h5040, 16'h0040, 16'h0041, 16'h0000, 1'b1, 1'b1, 1'b0);
      vecs[7]  = mk(1'b0, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0040, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0);
      vecs[8]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0040, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b1);
      vecs[9]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444, 16'h0004, 16'h0005, 16'h0010, 1'b1, 1'b0, 1'b1);
      vecs[10] = mk(1'b0, 1'b0, 16'h0000, 1'b1, OP_RTI,   16'h0005, 16'h0006, 16'h0010, 1'b1, 1'b0, 1'b1);
      vecs[11] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0005, 16'h0010, 16'h0010, 1'b0, 1'b1, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0005, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b1);
      vecs[13] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h4444, 16'h0004, 16'h0005, 16'h0010, 1'b1, 1'b0, 1'b1);
      vecs[14] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h4444, 16'h0004, 16'h0005, 16'h0010, 1'b1, 1'b0, 1'b1);
      vecs[15] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h4444, 16'h0004, 16'h0005, 16'h0010, 1'b1, 1'b0, 1'b1);
      vecs[16] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h4444, 16'h0004, 16'h0005, 16'h0010, 1'b1, 1'b0, 1'b1);
      vecs[17] = mk(1'b0, 1'b0, 16'h0000, 1'b0, OP_RTI,   16'h0005, 16'h0006, 16'h0010, 1'b1, 1'b0, 1'b1);
      vecs[18] = mk(1'b1, 1'b0, 16'h0000, 1'b0, OP_RTI,   16'h0005, 16'h0006, 16'h0010, 1'b1, 1'b0, 1'b1);
      vecs[19] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0005, 16'h0010, 16'h0010, 1'b0, 1'b1, 1'b0);
      vecs[20] = mk(1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000, 16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b1, 1'b0);
      vecs[21] = mk(1'b0, 1'b0, 16'h0000, 1'b0, OP_RTI,   16'h0005, 16'h0006, 16'h0010, 1'b1, 1'b1, 1'b0);
      vecs[22] = mk(1'b0, 1'b0, 16'h0000, 1'b0, OP_IOF,   16'h0006, 16'h0007, 16'h0010, 1'b1, 1'b1, 1'b0);
      vecs[23] = mk(1'b0, 1'b0, 16'h0000, 1'b0, OP_IEN,   16'h0007, 16'h0008, 16'h0010, 1'b1, 1'b0, 1'b0);
      vecs[24] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5008, 16'h0008, 16'h0009, 16'h0010, 1'b1, 1'b1, 1'b0);
      vecs[25] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0008, 16'h0004, 16'h0009, 1'b0, 1'b0, 1'b1);
      vecs[26] = mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0008, 16'hFFFF, 16'h0009, 1'b0, 1'b0, 1'b1);
      vecs[27] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h5FFF, 16'hFFFF, 16'h0000, 16'h0009, 1'b1, 1'b0, 1'b1);

      reset = 1'b1;
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      check("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int k = 0; k < NumVec; k++) begin
         step(vecs[k].stall, vecs[k].br, vecs[k].tgt, vecs[k].irq);
         check($sformatf("vec%0d", k), vecs[k].ir, vecs[k].pcd, vecs[k].addr, vecs[k].epc,
               vecs[k].valid, vecs[k].ie, vecs[k].isr);
      end

      // Reset while the handler is active, with irq still asserted.
      reset = 1'b1;
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      check("reset_in_isr", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step(1'b0, 1'b0, 16'h0000, 1'b1);
      check("post_reset_fetch", 16'h1000, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
